// File: rtl/rr_interval_gen_if.sv
// Output stream of the RR interval generator: FIFO head, valid flag and
// consumer ready, as a plain valid/ready handshake.
interface rr_interval_gen_if;
    logic [7:0] rr_out;
    logic       rr_valid;
    logic       rr_ready;

    modport master (
        output rr_out,
        output rr_valid,
        input  rr_ready
    );

    modport slave (
        input  rr_out,
        input  rr_valid,
        output rr_ready
    );
endinterface

// File: rtl/rr_interval_gen.sv
// RR interval generator: synchronizes raw R-peak pulses, measures the time
// between accepted beats in units of TICKS_PER_UNIT clocks, applies a
// refractory window, and queues the intervals in a 4-entry fall-through FIFO.
module rr_interval_gen #(
    parameter int TICKS_PER_UNIT = 1000,
    parameter int REFRACT_UNITS  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              beat_in,
    input  logic              clr_ovf,
    rr_interval_gen_if.master rr_bus,
    output logic              timeout,
    output logic              ovf,
    output logic [7:0]        beat_cnt
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        REFRACT,
        MEASURE
    } state_t;

    localparam logic [15:0] PRESC_MAX   = 16'(TICKS_PER_UNIT - 1);
    localparam logic [7:0]  REFRACT_LIM = 8'(REFRACT_UNITS);

    logic [2:0]  sync_q;
    logic        beat_evt;
    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [7:0]  cnt_inc;
    logic        unit_tick;
    state_t      state_q;
    state_t      state_d;
    logic        push_req;
    logic        timeout_d;

    logic [7:0]  fifo_mem [4];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        push_ok;
    logic        push_drop;

    // bit 0/1 form the metastability synchronizer, bit 2 delays for edge detect
    assign beat_evt  = sync_q[1] & ~sync_q[2];
    assign unit_tick = (presc_q == PRESC_MAX);
    // the saturating increment doubles as the captured interval on a beat
    assign cnt_inc   = (unit_tick && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    // Synchronize the asynchronous beat input and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], beat_in};
        end
    end

    // Measurement state, prescaler, interval counter and registered timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_FIRST;
            presc_q <= 16'd0;
            cnt_q   <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            timeout <= timeout_d;
        end
    end

    // Next-state logic: beats restart the count, refractory beats are ignored, overrun times out.
    always_comb begin
        state_d   = state_q;
        presc_d   = unit_tick ? 16'd0 : presc_q + 16'd1;
        cnt_d     = cnt_inc;
        push_req  = 1'b0;
        timeout_d = 1'b0;
        if (!ena) begin
            state_d = WAIT_FIRST;
            presc_d = 16'd0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                WAIT_FIRST: begin
                    if (beat_evt) begin
                        presc_d = 16'd0;
                        cnt_d   = 8'd0;
                        state_d = REFRACT;
                    end
                end
                REFRACT: begin
                    if (cnt_inc >= REFRACT_LIM) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (beat_evt) begin
                        push_req = 1'b1;
                        presc_d  = 16'd0;
                        cnt_d    = 8'd0;
                        state_d  = REFRACT;
                    end else if (unit_tick && cnt_q == 8'hFF) begin
                        timeout_d = 1'b1;
                        state_d   = WAIT_FIRST;
                    end
                end
                default: begin
                    state_d = WAIT_FIRST;
                end
            endcase
        end
    end

    // pointers carry an extra wrap bit so full and empty are distinguishable
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == 3'd4);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign pop        = ~fifo_empty & rr_bus.rr_ready;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;

    assign rr_bus.rr_valid = ~fifo_empty;
    assign rr_bus.rr_out   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[1:0]];

    // FIFO storage needs no reset; empty pointers mask stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[1:0]] <= cnt_inc;
        end
    end

    // FIFO pointers, sticky overflow flag (set beats clear) and accepted-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            ovf      <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr   <= wr_ptr + 3'd1;
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            if (push_drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_interval_gen.md
RR_INTERVAL_GEN -- requirements
Module: rr_interval_gen

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 1000: clk cycles per RR time unit; legal range 2..65535.
REQ-002 Parameter REFRACT_UNITS, default 40: minimum interval in units before a beat is accepted; legal range 1..254.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  1 = run; 0 = measurement halted.
REQ-006 beat_in  input  1  raw R-peak pulse, asynchronous to clk, high at least 2 clk cycles.
REQ-007 clr_ovf  input  1  synchronous clear of ovf.
REQ-008 rr_out  output  8  RR interval in units, FIFO head.
REQ-009 rr_valid  output  1  rr_out holds a valid interval.
REQ-010 rr_ready  input  1  consumer accepts rr_out when rr_valid and rr_ready are both 1.
REQ-011 timeout  output  1  one-cycle pulse on interval overrun.
REQ-012 ovf  output  1  sticky flag: an interval was dropped because the FIFO was full.
REQ-013 beat_cnt  output  8  count of intervals pushed into the FIFO, wraps 255->0.

Function
REQ-014 beat_in SHALL pass a 2-flop synchronizer followed by a third flop; beat_evt = stage2 AND NOT stage3.
REQ-015 The prescaler SHALL count 0..TICKS_PER_UNIT-1; unit_tick SHALL be 1 when the prescaler equals TICKS_PER_UNIT-1, and the prescaler wraps to 0 on that edge.
REQ-016 The interval counter is 8 bits; it SHALL increment on unit_tick, saturate at 255, and never wrap.
REQ-017 FSM states SHALL be WAIT_FIRST, REFRACT and MEASURE; reset state is WAIT_FIRST.
REQ-018 WAIT_FIRST: on beat_evt, clear the prescaler and counter and go to REFRACT; nothing is pushed.
REQ-019 REFRACT: beat_evt SHALL be ignored with no counter reset; go to MEASURE once the updated counter is >= REFRACT_UNITS.
REQ-020 MEASURE on beat_evt: capture = counter + unit_tick, saturated to 255; push the capture into the FIFO; clear the prescaler and counter; go to REFRACT.
REQ-021 Beats D cycles apart in MEASURE SHALL therefore yield floor(D/TICKS_PER_UNIT), saturated at 255.
REQ-022 MEASURE with unit_tick, counter == 255 and no beat_evt: pulse timeout for 1 cycle, push nothing, go to WAIT_FIRST.
REQ-023 beat_evt and timeout on the same edge: beat_evt wins; 255 is pushed and timeout does not pulse.
REQ-024 ena = 0 SHALL force WAIT_FIRST and hold the prescaler and counter at 0 synchronously; FIFO, ovf and beat_cnt are unaffected and pops continue.
REQ-025 FIFO: 4 entries, first-word fall-through; rr_valid = not empty; rr_out = oldest entry; pop on rr_valid AND rr_ready.
REQ-026 Push into an empty FIFO SHALL make rr_valid 1 in the cycle after the push edge.
REQ-027 Push when full without a same-cycle pop: the sample is dropped, ovf is set and beat_cnt is unchanged.
REQ-028 Push when full with a same-cycle pop: the push is accepted and ovf is unchanged.
REQ-029 beat_cnt SHALL increment on every accepted push.
REQ-030 Set and clear of ovf on the same edge: set wins.
REQ-031 Latency: if beat_in is first sampled high at edge N, the push occurs at edge N+2; rr_valid is 1 after edge N+2 when the FIFO was empty.
REQ-032 rr_out SHALL be stable while rr_valid = 1 and rr_ready = 0.

Reset
REQ-033 rst_n low SHALL asynchronously clear the synchronizer, prescaler, counter, FSM (to WAIT_FIRST) and FIFO pointers.
REQ-034 During reset: rr_out = 0, rr_valid = 0, timeout = 0, ovf = 0, beat_cnt = 0.
REQ-035 Reset mid-interval or with the FIFO non-empty SHALL discard all data; the first beat after release is treated as first beat (no push).
REQ-036 Deassertion of rst_n SHALL be synchronized to clk externally; the block samples normally from the first edge after release.

Verification (TICKS_PER_UNIT = 4, REFRACT_UNITS = 40)
REQ-037 Beats at cycles 0, 200 and 600, rr_ready = 1 -> two pushes, rr_out = 50 then 100; beat_cnt = 2; each rr_valid 1-cycle; push 2 edges after the synchronized sample.
REQ-038 Beat at 0, second beat at 100 (refractory), third at 300 -> single push of 75; the beat at 100 is ignored.
REQ-039 Beat at 0, no further beat -> timeout pulse at cycle ~1024 (unit tick with counter 255), no push, FSM in WAIT_FIRST; next two beats 240 apart -> 60.
REQ-040 rr_ready = 0, six measured intervals -> four held in order, ovf = 1, beat_cnt = 4; clr_ovf -> ovf = 0; draining gives the first four values.
REQ-041 Full FIFO with rr_ready = 1 on the push edge -> push accepted, ovf stays 0.
REQ-042 rst_n pulsed low mid-interval with 2 entries queued -> rr_valid = 0 immediately, beat_cnt = 0; the next beat produces no push.
